// File: rtl/bin2bcd_if.sv
// Valid/ready handshake bundle between the binary producer, the converter and
// the BCD consumer. The producer/consumer side is the master; the converter is the slave.
interface bin2bcd_if #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     digit_en;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, overflow, digit_en
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, overflow, digit_en
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Accepts a value in IDLE, iterates IN_WIDTH times in SHIFT and holds the
// result in DONE until the consumer takes it. It also provides a sticky
// overflow flag and a leading-zero blanking mask.
module bin2bcd_seq #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  bin2bcd_if.slave   bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [IN_WIDTH-1:0]  r_shift;
  logic [BW-1:0]        r_scratch;
  logic                 r_ovf;
  logic [CW-1:0]        r_cnt;

  logic [BW-1:0]        r_bcd;
  logic                 r_ovf_out;
  logic [DIGITS-1:0]    r_digit_en;

  logic [BW-1:0]        w_adj;
  logic [BW-1:0]        w_scratch_next;
  logic [IN_WIDTH-1:0]  w_shift_next;
  logic                 w_ovf_next;
  logic [DIGITS-1:0]    w_digit_en;
  logic                 w_any;
  logic                 w_last_iter;

  assign w_last_iter = (r_cnt == CW'(1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: accept in IDLE, count iterations, wait for the consumer.
  // NOTE: the default is assigned first so no path leaves w_state_next
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid)  w_state_next = S_SHIFT;
      S_SHIFT: if (w_last_iter)   w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.bcd       = r_bcd;
  assign bus.overflow  = r_ovf_out;
  assign bus.digit_en  = r_digit_en;

  // One double-dabble iteration plus the blanking mask of its result.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
    // The top adjusted bit falls off the end; it marks a value beyond 10^DIGITS-1.
    w_scratch_next = {w_adj[BW-2:0], r_shift[IN_WIDTH-1]};
    w_shift_next   = r_shift << 1;
    w_ovf_next     = r_ovf | w_adj[BW-1];

    // Scan from the top digit down; once a nonzero digit is seen, every lower
    // digit is shown. The ones digit is always shown.
    w_any      = 1'b0;
    w_digit_en = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_any         = w_any | (w_scratch_next[4*i +: 4] != 4'd0);
      w_digit_en[i] = w_any | (i == 0);
    end
  end

  // Datapath: load on accept, iterate in SHIFT, capture the result on the last iteration.
  // NOTE: scratch and result registers are reset too, so a conversion aborted
  // by reset can never surface a partial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_ovf_out  <= 1'b0;
      r_digit_en <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_shift   <= bus.bin;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= CW'(IN_WIDTH);
          end
        end
        S_SHIFT: begin
          r_shift   <= w_shift_next;
          r_scratch <= w_scratch_next;
          r_ovf     <= w_ovf_next;
          r_cnt     <= r_cnt - CW'(1);
          if (w_last_iter) begin
            r_bcd      <= w_scratch_next;
            r_ovf_out  <= w_ovf_next;
            r_digit_en <= w_digit_en;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 5-digit and a 4-digit instance share one stimulus
// stream. An arithmetic reference (repeated divide by ten) predicts every
// output on every cycle, and directed vectors pin the reference with literals.
module tb_bin2bcd_seq;

  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [IW-1:0] bin = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int unsigned v;
    int          acc;
  } item_t;
  item_t q[$];

  always #5 clk = ~clk;

  bin2bcd_if #(.IN_WIDTH(IW), .DIGITS(5)) if5 ();
  bin2bcd_if #(.IN_WIDTH(IW), .DIGITS(4)) if4 ();

  assign if5.in_valid  = in_valid;
  assign if5.bin       = bin;
  assign if5.out_ready = out_ready;
  assign if4.in_valid  = in_valid;
  assign if4.bin       = bin;
  assign if4.out_ready = out_ready;

  bin2bcd_seq #(.IN_WIDTH(IW), .DIGITS(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
  bin2bcd_seq #(.IN_WIDTH(IW), .DIGITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [63:0] model_bcd(input longint unsigned v, input int d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint unsigned pow10(input int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [63:0] model_ovf(input longint unsigned v, input int d);
    return {63'd0, v >= pow10(d)};
  endfunction

  // Mask of the significant decimal digits of (v mod 10^d), at least one.
  function automatic logic [63:0] model_en(input longint unsigned v, input int d);
    longint unsigned m;
    int nd;
    m  = v % pow10(d);
    nd = 1;
    while (m >= 10) begin
      m = m / 10;
      nd++;
    end
    return (64'd1 << nd) - 64'd1;
  endfunction

  // Monitor on the active edge: count cycles, track accepted and consumed values.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (q.size() > 0 && if5.out_valid && out_ready) void'(q.pop_front());
      if (in_valid && if5.in_ready) q.push_back('{v: 32'(bin), acc: cyc});
    end
  end

  // Compare process: every falling edge, all outputs against the reference.
  always @(negedge clk) begin
    bit busy;
    bit exp_ov;
    if (!rst_n) begin
      check("rst_in_ready",  64'(if5.in_ready),  64'd1);
      check("rst_out_valid", 64'(if5.out_valid), 64'd0);
      check("rst_bcd",       64'(if5.bcd),       64'd0);
      check("rst_overflow",  64'(if5.overflow),  64'd0);
      check("rst_digit_en",  64'(if5.digit_en),  64'd0);
    end else begin
      busy   = (q.size() > 0);
      exp_ov = busy && ((cyc - q[0].acc) >= IW);
      check("in_ready",   64'(if5.in_ready),  64'(!busy));
      check("out_valid",  64'(if5.out_valid), 64'(exp_ov));
      check("out_valid4", 64'(if4.out_valid), 64'(exp_ov));
      if (exp_ov) begin
        check("bcd5",      64'(if5.bcd),      model_bcd(q[0].v, 5));
        check("overflow5", 64'(if5.overflow), model_ovf(q[0].v, 5));
        check("digit_en5", 64'(if5.digit_en), model_en(q[0].v, 5));
        check("bcd4",      64'(if4.bcd),      model_bcd(q[0].v, 4));
        check("overflow4", 64'(if4.overflow), model_ovf(q[0].v, 4));
        check("digit_en4", 64'(if4.digit_en), model_en(q[0].v, 4));
      end
    end
  end

  // Present v and hold in_valid until the accepting edge has passed.
  task automatic send(input logic [IW-1:0] v);
    int k;
    k = 0;
    @(negedge clk); #1;
    bin = v;
    in_valid = 1'b1;
    while (!if5.in_ready && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 100) check("accept_timeout", 64'(k), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin = IW'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!if5.out_valid && lat < 100);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input logic [IW-1:0] v, input logic [19:0] e_bcd5,
                         input logic [4:0] e_en5, input logic [15:0] e_bcd4,
                         input logic e_ovf4);
    int lat;
    send(v);
    wait_valid(lat);
    check("latency",  64'(lat),          64'(IW));
    check("lit_bcd5", 64'(if5.bcd),      64'(e_bcd5));
    check("lit_en5",  64'(if5.digit_en), 64'(e_en5));
    check("lit_ovf5", 64'(if5.overflow), 64'd0);
    check("lit_bcd4", 64'(if4.bcd),      64'(e_bcd4));
    check("lit_ovf4", 64'(if4.overflow), 64'(e_ovf4));
    take();
  endtask

  initial begin
    int lat;
    int prev_acc;
    int acc;
    int k;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("lit_rst_in_ready",  64'(if5.in_ready),  64'd1);
    check("lit_rst_out_valid", 64'(if5.out_valid), 64'd0);
    check("lit_rst_bcd",       64'(if5.bcd),       64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors with literal expectations.
    run_vec(16'd0,     20'h00000, 5'b00001, 16'h0000, 1'b0);
    run_vec(16'd65535, 20'h65535, 5'b11111, 16'h5535, 1'b1);
    run_vec(16'd9999,  20'h09999, 5'b01111, 16'h9999, 1'b0);
    run_vec(16'd12345, 20'h12345, 5'b11111, 16'h2345, 1'b1);
    run_vec(16'd42,    20'h00042, 5'b00011, 16'h0042, 1'b0);

    // Backpressure: result held for 6 cycles, stray input ignored.
    send(16'd500);
    wait_valid(lat);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("bp_out_valid", 64'(if5.out_valid), 64'd1);
      check("bp_in_ready",  64'(if5.in_ready),  64'd0);
      check("bp_bcd",       64'(if5.bcd),       64'h00500);
      if (i == 2) begin
        bin = 16'd123;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    take();
    check("bp_idle_in_ready",  64'(if5.in_ready),  64'd1);
    check("bp_idle_out_valid", 64'(if5.out_valid), 64'd0);
    check("bp_bcd_kept",       64'(if5.bcd),       64'h00500);
    run_vec(16'd123, 20'h00123, 5'b00111, 16'h0123, 1'b0);

    // Reset in the middle of SHIFT.
    send(16'd54321);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(if5.out_valid), 64'd0);
    check("mid_rst_bcd",       64'(if5.bcd),       64'd0);
    check("mid_rst_in_ready",  64'(if5.in_ready),  64'd1);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_vec(16'd7, 20'h00007, 5'b00001, 16'h0007, 1'b0);

    // Back-to-back: in_valid and out_ready held high, 100 random values.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_acc  = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      bin = IW'($urandom_range(0, 65535));
      k = 0;
      while (!if5.in_ready && k < 60) begin
        @(negedge clk); #1;
        k++;
      end
      if (k >= 60) check("b2b_timeout", 64'(k), 64'd0);
      acc = cyc + 1;
      if (n > 0) check("b2b_spacing", 64'(acc - prev_acc), 64'(IW + 2));
      prev_acc = acc;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    repeat (IW + 4) @(posedge clk);
    #1;
    check("b2b_drained", 64'(if5.in_ready), 64'd1);
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
